jtgng_shctl: RTL and testbench
==============================

JTGNG_SHCTL -- requirements
Module: jtgng_shctl

Interface
REQ-001 Parameter WIDTH, default 5, data bits per word.
REQ-002 Parameter STAGES, default 24, delay depth in shift events; legal range 2..255.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port cen, input, 1, global clock enable; no state changes when low.
REQ-006 Port din, input, WIDTH, word to delay.
REQ-007 Port din_valid, input, 1, din holds a word to enqueue.
REQ-008 Port din_ready, output, 1, word is accepted this cycle if din_valid & cen.
REQ-009 Port stall, input, 1, freeze the delay line (RUN/IDLE only).
REQ-010 Port flush, input, 1, level; request to drain all in-flight words.
REQ-011 Port dout, output, WIDTH, word at the delay-line tail, forced to 0 when dout_valid low.
REQ-012 Port dout_valid, output, 1, level: dout carries a valid word.
REQ-013 Port dout_strobe, output, 1, pulse: the valid tail word leaves this cycle.
REQ-014 Port count, output, clog2(STAGES+1), number of valid words in flight.
REQ-015 Port busy, output, 1, high when state is not IDLE.

Function
REQ-016 The block SHALL own one WIDTH x STAGES delay line plus a STAGES-bit valid shadow that shift in lockstep.
REQ-017 shift = cen & ((state==FLUSH) | ~stall).
REQ-018 din_ready = (state!=FLUSH) & ~stall & ~flush, combinational.
REQ-019 accept = din_valid & din_ready & cen; on shift the shadow head takes accept and the line head takes din when accept, else 0.
REQ-020 dout_valid = shadow[STAGES-1]; dout_strobe = shift & dout_valid.
REQ-021 A word accepted on shift event N SHALL show dout_valid from the cycle after event N+STAGES-1 and produce dout_strobe on event N+STAGES.
REQ-022 count SHALL increment on accept without strobe, decrement on strobe without accept, hold when both or neither occur; it never exceeds STAGES.
REQ-023 States: IDLE, RUN, FLUSH.
REQ-024 IDLE->RUN on accept; IDLE->FLUSH never (flush with count==0 stays IDLE).
REQ-025 RUN->IDLE when count reaches 0 with no accept; RUN->FLUSH on cen & flush.
REQ-026 FLUSH shifts on every cen regardless of stall, inserts invalid words, and goes to IDLE on the cycle count reaches 0.
REQ-027 flush is ignored while in FLUSH; flush and din_valid in the same cycle: flush wins, word not accepted.
REQ-028 Words drained during FLUSH SHALL still produce dout_valid/dout_strobe (no data loss).
REQ-029 stall with cen low is a no-op; stall in RUN holds dout, dout_valid and count constant.

Reset
REQ-030 On rst: state IDLE, shadow all 0, count 0, dout 0, dout_valid 0, dout_strobe 0, busy 0; din_ready follows REQ-018.
REQ-031 Delay-line data bits need no reset; outputs SHALL be defined through REQ-011 masking.
REQ-032 rst mid-FLUSH or mid-RUN SHALL discard all in-flight words with no dout_strobe.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, RUN, FLUSH) and the count-width function.
REQ-034 The data path SHALL be one sub-module instance, jtgng_sh, with clk_en driven by shift and din driven by the masked head word; shadow, counter and FSM live in jtgng_shctl.

Verification
REQ-035 Defaults, cen=1: accept din=5'h15 at cycle 0 -> dout=5'h15, dout_valid at cycle 24, dout_strobe at cycle 24, count back to 0, busy low at cycle 25.
REQ-036 cen toggled 1-of-3, 30 consecutive words 0..29 -> outputs 0..29 in order, 24 shift events latency each, count saturates at 24.
REQ-037 Stall 10 cycles with count=7 -> dout, count unchanged, din_ready=0; release -> latency extended by exactly 10.
REQ-038 Flush with count=12 while stall=1 and din_valid=1 -> din not accepted, 12 strobes, FLUSH->IDLE within 24 cen cycles, count=0.
REQ-039 Flush at count=0 -> state stays IDLE, no strobes; flush and din_valid same cycle -> no accept.
REQ-040 rst asserted mid-FLUSH with count=9 -> immediately dout_valid=0, dout=0, count=0, no strobe after release.

Source files
------------

// File: rtl/jtgng_shctl_pkg.sv
// Shared types and helpers for the shift-delay controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package jtgng_shctl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Bits needed to count 0..stages valid words in flight
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/jtgng_sh.sv
// Plain WIDTH x STAGES shift register; data bits carry no reset.
// Latency: STAGES clk_en events from din to drop.
// Backpressure: none; clk_en low freezes every stage.
module jtgng_sh
  import jtgng_shctl_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 24
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);

  logic [WIDTH-1:0] line [STAGES];

  // Advance the whole line by one stage on every enabled clock
  always_ff @(posedge clk) begin
    if (clk_en) begin
      line[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign drop = line[STAGES-1];

endmodule

// File: rtl/jtgng_shctl.sv
// Fixed-depth delay line with valid shadow, in-flight counter and flush FSM.
// Latency: a word accepted on shift event N leaves (dout_strobe) on event N+STAGES.
// Backpressure: din_ready drops on stall, flush or while draining; FLUSH ignores stall.
module jtgng_shctl
  import jtgng_shctl_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 24,
  localparam int CW    = cnt_w(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_strobe,
  output logic [CW-1:0]    count,
  output logic             busy
);

  state_t            state;
  state_t            state_nxt;
  logic [STAGES-1:0] shadow;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              shift;
  logic              accept;
  logic [WIDTH-1:0]  head;
  logic [WIDTH-1:0]  tail;

  // Draining keeps the line moving even when the consumer asks to stall
  assign shift     = cen & ((state == FLUSH) | ~stall);
  assign din_ready = (state != FLUSH) & ~stall & ~flush;
  assign accept    = din_valid & din_ready & cen;

  // Empty slots enter as zero so stale data never reaches the head
  assign head = accept ? din : '0;

  jtgng_sh #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sh (
    .clk    (clk),
    .clk_en (shift),
    .din    (head),
    .drop   (tail)
  );

  assign dout_valid  = shadow[STAGES-1];
  assign dout_strobe = shift & dout_valid;
  assign dout        = dout_valid ? tail : '0;
  assign count       = count_q;
  assign busy        = (state != IDLE);

  // Valid shadow moves in lockstep with the data line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (shift) begin
      shadow <= {shadow[STAGES-2:0], accept};
    end
  end

  // In-flight count: simultaneous enter and leave cancel out
  always_comb begin
    count_nxt = count_q;
    if (accept && !dout_strobe) begin
      count_nxt = count_q + 1'b1;
    end else if (dout_strobe && !accept) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Counter and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state   <= IDLE;
    end else begin
      count_q <= count_nxt;
      state   <= state_nxt;
    end
  end

  // Next-state: leave RUN/FLUSH as soon as the line empties
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count_nxt == '0 && !accept) begin
          state_nxt = IDLE;
        end else if (cen && flush) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (count_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtgng_shctl.sv
// Directed bench for jtgng_shctl at default parameters (WIDTH 5, STAGES 24).
// Latency: n/a.
// Backpressure: n/a.
module tb_jtgng_shctl;

  localparam int WIDTH  = 5;
  localparam int STAGES = 24;
  localparam int CW     = $clog2(STAGES + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cen;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_strobe;
  logic [CW-1:0]    count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  jtgng_shctl #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .stall       (stall),
    .flush       (flush),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_strobe (dout_strobe),
    .count       (count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard stop if something runs away
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nout, ev, maxc, widx, fc, ns;
    int acc_q[$];

    rst = 1'b1; cen = 1'b0; din = '0; din_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid",  dout_valid, 0);
    chk("rst_dout",   dout, 0);
    chk("rst_strobe", dout_strobe, 0);
    chk("rst_count",  count, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_ready",  din_ready, 1);
    rst = 1'b0; cen = 1'b1;
    step();

    // Single word, full-rate cen
    din = 5'h15; din_valid = 1'b1;
    #1;
    chk("single_ready", din_ready, 1);
    step();
    din_valid = 1'b0; din = '0;
    repeat (22) step();
    #1;
    chk("single_c23_valid", dout_valid, 0);
    chk("single_c23_count", count, 1);
    step();
    #1;
    chk("single_c24_valid",  dout_valid, 1);
    chk("single_c24_dout",   dout, 5'h15);
    chk("single_c24_strobe", dout_strobe, 1);
    step();
    #1;
    chk("single_c25_count", count, 0);
    chk("single_c25_busy",  busy, 0);
    chk("single_c25_valid", dout_valid, 0);

    // Stream of 30 words with cen one cycle in three
    nout = 0; ev = 0; maxc = 0; widx = 0;
    for (int c = 0; c < 600 && nout < 30; c++) begin
      cen       = (c % 3 == 0);
      din_valid = (widx < 30);
      din       = widx[WIDTH-1:0];
      #1;
      if (cen && widx < 30) begin
        acc_q.push_back(ev);
        widx++;
      end
      if (dout_strobe) begin
        chk("stream_dout", dout, nout);
        chk("stream_latency", ev - acc_q.pop_front(), STAGES);
        nout++;
      end
      if (int'(count) > maxc) maxc = int'(count);
      if (cen) ev++;
      step();
    end
    cen = 1'b1; din_valid = 1'b0; din = '0;
    #1;
    chk("stream_nout",  nout, 30);
    chk("stream_max",   maxc, STAGES);
    chk("stream_count", count, 0);
    chk("stream_busy",  busy, 0);
    step();

    // Stall for 10 cycles with seven words in flight, head word at the tail
    for (int i = 0; i < 7; i++) begin
      din = 5'(8 + i); din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0; din = '0;
    repeat (17) step();
    stall = 1'b1;
    for (int s = 0; s < 10; s++) begin
      #1;
      chk("stall_dout",   dout, 8);
      chk("stall_valid",  dout_valid, 1);
      chk("stall_count",  count, 7);
      chk("stall_strobe", dout_strobe, 0);
      chk("stall_ready",  din_ready, 0);
      step();
    end
    stall = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("stall_rel_strobe", dout_strobe, 1);
      chk("stall_rel_dout",   dout, 8 + i);
      step();
    end
    #1;
    chk("stall_end_count", count, 0);
    chk("stall_end_busy",  busy, 0);

    // Flush with twelve in flight while stalled and offering a word
    for (int i = 0; i < 12; i++) begin
      din = 5'(20 + i); din_valid = 1'b1;
      step();
    end
    stall = 1'b1; flush = 1'b1; din = 5'h1f; din_valid = 1'b1;
    #1;
    chk("flush_ready",  din_ready, 0);
    chk("flush_count",  count, 12);
    chk("flush_strobe", dout_strobe, 0);
    step();
    flush = 1'b0;
    ns = 0; fc = 0;
    while (busy && fc < 40) begin
      #1;
      if (dout_strobe) begin
        chk("flush_dout", dout, 20 + ns);
        ns++;
      end
      step();
      fc++;
    end
    #1;
    chk("flush_strobes", ns, 12);
    chk("flush_cycles",  fc, 24);
    chk("flush_count0",  count, 0);
    chk("flush_busy0",   busy, 0);
    stall = 1'b0; din_valid = 1'b0; din = '0;
    step();

    // Flush with nothing in flight, flush beats din_valid
    flush = 1'b1; din_valid = 1'b1; din = 5'h03;
    #1;
    chk("flush0_ready", din_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("flush0_busy",   busy, 0);
      chk("flush0_count",  count, 0);
      chk("flush0_strobe", dout_strobe, 0);
    end
    flush = 1'b0; din = 5'h09; din_valid = 1'b1;
    step();
    flush = 1'b1; din = 5'h0a;
    #1;
    chk("flushdin_ready", din_ready, 0);
    step();
    flush = 1'b0; din_valid = 1'b0; din = '0;
    #1;
    chk("flushdin_count", count, 1);
    chk("flushdin_busy",  busy, 1);
    ns = 0; fc = 0;
    while (busy && fc < 40) begin
      #1;
      if (dout_strobe) begin
        chk("flushdin_dout", dout, 5'h09);
        ns++;
      end
      step();
      fc++;
    end
    chk("flushdin_strobes", ns, 1);
    chk("flushdin_idle",    busy, 0);

    // Reset in the middle of a flush with nine in flight
    for (int i = 0; i < 9; i++) begin
      din = 5'(i + 1); din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0; din = '0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("midrst_busy_before", busy, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid",  dout_valid, 0);
    chk("midrst_dout",   dout, 0);
    chk("midrst_count",  count, 0);
    chk("midrst_busy",   busy, 0);
    chk("midrst_strobe", dout_strobe, 0);
    step();
    rst = 1'b0;
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (dout_strobe || dout_valid) ns++;
      step();
    end
    chk("midrst_no_strobe", ns, 0);
    chk("midrst_count_end", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
